// File: rtl/apb4_sram_pkg.sv
// Shared types and helpers for the APB4 SRAM slave.
// Parity lanes are enabled by defining APB4_SRAM_PARITY_EN.
package apb4_sram_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_ACCESS = ACCESS;

    localparam int unsigned MAX_WAIT_STATES = 15;

    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input int unsigned lane_bits);
        return byte_addr >> lane_bits;
    endfunction

    // Even parity: the stored bit makes the byte plus parity have an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/apb4_sram_mem.sv
// Synchronous byte-enable RAM with a registered, enable-gated read port.
// With APB4_SRAM_PARITY_EN defined, one even-parity bit per byte is kept alongside the data.
module apb4_sram_mem
    import apb4_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int ADDR_W     = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic                    rd_clr,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
`ifdef APB4_SRAM_PARITY_EN
    , output logic [DATA_WIDTH/8-1:0] rd_par
`endif
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`ifdef APB4_SRAM_PARITY_EN
    logic [STRB_WIDTH-1:0] par_q [DEPTH];
`endif

    // Storage itself is never reset; only written lanes change.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wr_strb[i]) begin
                    mem_q[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
`ifdef APB4_SRAM_PARITY_EN
                    par_q[wr_addr][i] <= byte_parity(wr_data[i*8 +: 8]);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || rd_clr) begin
            rd_data <= '0;
`ifdef APB4_SRAM_PARITY_EN
            rd_par  <= '0;
`endif
        end else if (rd_en) begin
            rd_data <= mem_q[rd_addr];
`ifdef APB4_SRAM_PARITY_EN
            rd_par  <= par_q[rd_addr];
`endif
        end
    end

endmodule

// File: rtl/apb4_sram.sv
// APB4 slave fronting a byte-enable SRAM with wait states, error and privilege checks.
// Define APB4_SRAM_PARITY_EN to add per-byte parity and the parity_err output.
module apb4_sram
    import apb4_sram_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1,
    parameter int PROT_BASE   = DEPTH / 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
`ifdef APB4_SRAM_PARITY_EN
    , output logic                  parity_err
`endif
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LANE_BITS  = $clog2(STRB_WIDTH);
    localparam int MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > int'(MAX_WAIT_STATES)) ?
                                       4'(MAX_WAIT_STATES) : 4'(WAIT_STATES);

    logic [0:0]            state;
    logic [3:0]            wait_cnt;
    logic                  pwrite_q;
    logic                  err_q;
    logic [MEM_AW-1:0]     widx_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_WIDTH-1:0] pstrb_q;
    logic [31:0]           setup_idx;
    logic                  setup;
    logic                  err_now;
    logic                  mem_wr_en;
    logic                  unused_prot;

    // Only the privilege bit matters here; secure/instruction bits are accepted and ignored.
    assign unused_prot = ^pprot[2:1];

    assign setup_idx = word_index(32'(paddr), LANE_BITS);
    assign setup     = (state == ST_IDLE) && psel && !penable;
    assign err_now   = (setup_idx >= 32'(DEPTH))
                    || (paddr[LANE_BITS-1:0] != '0)
                    || (pwrite && (setup_idx >= 32'(PROT_BASE)) && !pprot[0]);

    assign pready    = (state == ST_ACCESS) && psel && (wait_cnt == 4'd0);
    assign mem_wr_en = pready && pwrite_q && !err_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        state    <= ST_ACCESS;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                default: begin
                    if (!psel || wait_cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    // The whole request is frozen at setup so the bus may change during ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwrite_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (setup) begin
            pwrite_q <= pwrite;
            err_q    <= err_now;
            widx_q   <= setup_idx[MEM_AW-1:0];
            pwdata_q <= pwdata;
            pstrb_q  <= pstrb;
        end
    end

`ifdef APB4_SRAM_PARITY_EN
    logic [STRB_WIDTH-1:0] rd_par;
    logic [STRB_WIDTH-1:0] par_calc;
    logic                  par_bad;
`endif

    apb4_sram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mem_wr_en),
        .wr_addr (widx_q),
        .wr_data (pwdata_q),
        .wr_strb (pstrb_q),
        .rd_en   (setup && !pwrite && !err_now),
        .rd_clr  (setup && !pwrite && err_now),
        .rd_addr (setup_idx[MEM_AW-1:0]),
        .rd_data (prdata)
`ifdef APB4_SRAM_PARITY_EN
        , .rd_par (rd_par)
`endif
    );

`ifdef APB4_SRAM_PARITY_EN
    always_comb begin
        par_calc = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            par_calc[i] = byte_parity(prdata[i*8 +: 8]);
        end
    end

    assign par_bad    = !pwrite_q && !err_q && (rd_par != par_calc);
    assign parity_err = pready && par_bad;
    assign pslverr    = pready && (err_q || par_bad);
`else
    assign pslverr    = pready && err_q;
`endif

endmodule

// File: tb/tb_apb4_sram.sv
// Bench for apb4_sram: a 32-bit WAIT_STATES=1 instance and a 64-bit WAIT_STATES=0 instance.
// Build with APB4_SRAM_PARITY_EN defined to also exercise the parity lanes.
module tb_apb4_sram;

    localparam int DEPTH     = 512;
    localparam int PROT_BASE = DEPTH / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [11:0] paddr;
    logic        psel, penable, pwrite;
    logic [2:0]  pprot;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;

    logic [11:0] w_paddr;
    logic        w_psel, w_penable, w_pwrite;
    logic [2:0]  w_pprot;
    logic [63:0] w_pwdata;
    logic [7:0]  w_pstrb;
    logic        w_pready, w_pslverr;
    logic [63:0] w_prdata;

`ifdef APB4_SRAM_PARITY_EN
    logic parity_err, w_parity_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem  [DEPTH];
    logic [3:0]  model_mask [DEPTH];

    logic [63:0] rd;
    logic        se;
    logic        pe;
    int          cyc;

    apb4_sram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(DEPTH), .WAIT_STATES(1), .PROT_BASE(PROT_BASE)
    ) dut (
        .clk(clk), .reset(reset), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
`ifdef APB4_SRAM_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    apb4_sram #(
        .DATA_WIDTH(64), .ADDR_WIDTH(12), .DEPTH(DEPTH), .WAIT_STATES(0), .PROT_BASE(PROT_BASE)
    ) dut64 (
        .clk(clk), .reset(reset), .paddr(w_paddr), .psel(w_psel), .penable(w_penable),
        .pwrite(w_pwrite), .pprot(w_pprot), .pwdata(w_pwdata), .pstrb(w_pstrb),
        .pready(w_pready), .prdata(w_prdata), .pslverr(w_pslverr)
`ifdef APB4_SRAM_PARITY_EN
        , .parity_err(w_parity_err)
`endif
    );

    // One APB transfer, starting right after a rising edge and returning right after the completing edge.
    task automatic xfer(input bit wide, input logic [11:0] addr, input bit wr,
                        input logic [63:0] wdata, input logic [7:0] strb, input logic [2:0] prot,
                        output logic [63:0] rdata, output logic slverr, output int cycles,
                        output logic perr);
        bit done;
        rdata = '0; slverr = 1'b0; perr = 1'b0; cycles = 0; done = 1'b0;
        if (wide) begin
            w_psel = 1'b1; w_penable = 1'b0; w_paddr = addr; w_pwrite = wr;
            w_pwdata = wdata; w_pstrb = strb; w_pprot = prot;
        end else begin
            psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
            pwdata = wdata[31:0]; pstrb = strb[3:0]; pprot = prot;
        end
        @(posedge clk); #1;
        if (wide) w_penable = 1'b1; else penable = 1'b1;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (wide ? w_pready : pready) begin
                rdata  = wide ? w_prdata : {32'h0, prdata};
                slverr = wide ? w_pslverr : pslverr;
`ifdef APB4_SRAM_PARITY_EN
                perr   = wide ? w_parity_err : parity_err;
`endif
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            total++; bad++;
            $display("[TB] FAIL xfer_timeout: addr=%h no pready after %0d cycles", addr, cycles);
        end
    endtask

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0; w_psel = 1'b0; w_penable = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pprot = '0; pwdata = '0; pstrb = '0;
        w_psel = 1'b0; w_penable = 1'b0; w_pwrite = 1'b0; w_paddr = '0; w_pprot = '0;
        w_pwdata = '0; w_pstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (pready !== 1'b0) begin bad++; $display("[TB] FAIL reset_pready: got %b want 0", pready); end
        total++; if (pslverr !== 1'b0) begin bad++; $display("[TB] FAIL reset_pslverr: got %b want 0", pslverr); end
        total++; if (prdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_prdata: got %h want 0", prdata); end
        total++; if (w_prdata !== 64'h0) begin bad++; $display("[TB] FAIL reset_prdata64: got %h want 0", w_prdata); end
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        xfer(0, 12'h010, 1, 64'hDEADBEEF, 8'hF, 3'b000, rd, se, cyc, pe);
        total++; if (cyc !== 2) begin bad++; $display("[TB] FAIL basic_wr_latency: got %0d want 2", cyc); end
        total++; if (se !== 1'b0) begin bad++; $display("[TB] FAIL basic_wr_slverr: got %b want 0", se); end
        xfer(0, 12'h010, 0, 64'h0, 8'h0, 3'b000, rd, se, cyc, pe);
        total++; if (rd[31:0] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL basic_rd_data: got %h want deadbeef", rd[31:0]); end
        total++; if (cyc !== 2) begin bad++; $display("[TB] FAIL basic_rd_latency: got %0d want 2", cyc); end
        idle(3);
        @(negedge clk);
        total++; if (prdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL basic_rd_hold: got %h want deadbeef", prdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_strobes();
        xfer(0, 12'h020, 1, 64'h11223344, 8'hF, 3'b000, rd, se, cyc, pe);
        xfer(0, 12'h020, 1, 64'hAABBCCDD, 8'h5, 3'b000, rd, se, cyc, pe);
        xfer(0, 12'h020, 0, 64'h0, 8'h0, 3'b000, rd, se, cyc, pe);
        total++; if (rd[31:0] !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL strobe_merge: got %h want 11bb33dd", rd[31:0]); end
        xfer(0, 12'h020, 1, 64'hFFFFFFFF, 8'h0, 3'b000, rd, se, cyc, pe);
        total++; if (se !== 1'b0) begin bad++; $display("[TB] FAIL strobe_zero_slverr: got %b want 0", se); end
        xfer(0, 12'h020, 0, 64'h0, 8'h0, 3'b000, rd, se, cyc, pe);
        total++; if (rd[31:0] !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL strobe_zero_noop: got %h want 11bb33dd", rd[31:0]); end
        idle(1);
    endtask

    task automatic test_errors();
        xfer(0, 12'(PROT_BASE*4), 1, 64'h12345678, 8'hF, 3'b001, rd, se, cyc, pe);
        total++; if (se !== 1'b0) begin bad++; $display("[TB] FAIL err_priv_wr_ok: got %b want 0", se); end
        xfer(0, 12'(PROT_BASE*4), 1, 64'hFFFFFFFF, 8'hF, 3'b000, rd, se, cyc, pe);
        total++; if (se !== 1'b1) begin bad++; $display("[TB] FAIL err_unpriv_wr: got %b want 1", se); end
        xfer(0, 12'(PROT_BASE*4), 0, 64'h0, 8'h0, 3'b000, rd, se, cyc, pe);
        total++; if (rd[31:0] !== 32'h12345678) begin bad++; $display("[TB] FAIL err_unpriv_kept: got %h want 12345678", rd[31:0]); end
        xfer(0, 12'(DEPTH*4), 0, 64'h0, 8'h0, 3'b000, rd, se, cyc, pe);
        total++; if (se !== 1'b1) begin bad++; $display("[TB] FAIL err_oob_rd: got %b want 1", se); end
        total++; if (rd[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL err_oob_rd_data: got %h want 0", rd[31:0]); end
        total++; if (cyc !== 2) begin bad++; $display("[TB] FAIL err_oob_latency: got %0d want 2", cyc); end
        xfer(0, 12'h802, 1, 64'h55555555, 8'hF, 3'b001, rd, se, cyc, pe);
        total++; if (se !== 1'b1) begin bad++; $display("[TB] FAIL err_802_wr: got %b want 1", se); end
        xfer(0, 12'h012, 1, 64'h0, 8'hF, 3'b001, rd, se, cyc, pe);
        total++; if (se !== 1'b1) begin bad++; $display("[TB] FAIL err_misalign_wr: got %b want 1", se); end
        xfer(0, 12'h010, 0, 64'h0, 8'h0, 3'b000, rd, se, cyc, pe);
        total++; if (rd[31:0] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL err_misalign_kept: got %h want deadbeef", rd[31:0]); end
        idle(1);
    endtask

    task automatic test_ignore_penable();
        bit seen;
        seen = 1'b0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h010; pwdata = '0; pstrb = 4'hF; pprot = 3'b001;
        repeat (4) begin
            @(negedge clk);
            if (pready) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL ignore_penable_pready: got 1 want 0"); end
        idle(1);
        xfer(0, 12'h010, 0, 64'h0, 8'h0, 3'b000, rd, se, cyc, pe);
        total++; if (rd[31:0] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL ignore_penable_mem: got %h want deadbeef", rd[31:0]); end
        idle(1);
    endtask

    task automatic test_abort();
        bit seen;
        seen = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020; pwdata = '0; pstrb = 4'hF; pprot = 3'b000;
        @(posedge clk); #1;
        penable = 1'b1; psel = 1'b0;
        @(negedge clk);
        total++; if (pready !== 1'b0) begin bad++; $display("[TB] FAIL abort_pready: got %b want 0", pready); end
        @(posedge clk); #1;
        // A stale access phase after the abort must not revive the transfer.
        psel = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (pready) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL abort_revived: got 1 want 0"); end
        idle(1);
        xfer(0, 12'h020, 0, 64'h0, 8'h0, 3'b000, rd, se, cyc, pe);
        total++; if (rd[31:0] !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL abort_mem: got %h want 11bb33dd", rd[31:0]); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020; pwdata = '0; pstrb = 4'hF; pprot = 3'b000;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        total++; if (pready !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_pready: got %b want 0", pready); end
        total++; if (pslverr !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_pslverr: got %b want 0", pslverr); end
        total++; if (prdata !== 32'h0) begin bad++; $display("[TB] FAIL rstmid_prdata: got %h want 0", prdata); end
        @(posedge clk); #1;
        xfer(0, 12'h020, 0, 64'h0, 8'h0, 3'b000, rd, se, cyc, pe);
        total++; if (rd[31:0] !== 32'h11BB33DD) begin bad++; $display("[TB] FAIL rstmid_mem: got %h want 11bb33dd", rd[31:0]); end
        idle(1);
    endtask

    task automatic test_random();
        int          idx;
        bit          wr;
        bit          exp_err;
        logic [11:0] addr;
        logic [2:0]  prot;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [31:0] exp_data;
        logic [31:0] bmask;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: idx = 32 + int'($urandom_range(0, 7));
                5, 6, 7:       idx = PROT_BASE + 1 + int'($urandom_range(0, 3));
                default:       idx = DEPTH + int'($urandom_range(0, 3));
            endcase
            addr = 12'(idx * 4);
            if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            wr   = 1'($urandom_range(0, 1));
            prot = 3'($urandom_range(0, 7));
            strb = 4'($urandom);
            wd   = $urandom;
            exp_err = (idx >= DEPTH) || (addr[1:0] != 2'b00) || (wr && idx >= PROT_BASE && !prot[0]);
            xfer(0, addr, wr, {32'h0, wd}, {4'h0, strb}, prot, rd, se, cyc, pe);
            total++; if (se !== exp_err) begin bad++; $display("[TB] FAIL rand_slverr: op %0d addr %h got %b want %b", n, addr, se, exp_err); end
            total++; if (cyc !== 2) begin bad++; $display("[TB] FAIL rand_latency: op %0d got %0d want 2", n, cyc); end
            if (wr && !exp_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) begin
                        model_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
                        model_mask[idx][b] = 1'b1;
                    end
                end
            end else if (!wr) begin
                exp_data = exp_err ? 32'h0 : model_mem[idx];
                bmask = '0;
                for (int b = 0; b < 4; b++) begin
                    if (exp_err || model_mask[idx][b]) bmask[b*8 +: 8] = 8'hFF;
                end
                total++;
                if (((rd[31:0] ^ exp_data) & bmask) !== 32'h0) begin
                    bad++;
                    $display("[TB] FAIL rand_rdata: op %0d addr %h got %h want %h (mask %h)", n, addr, rd[31:0], exp_data, bmask);
                end
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [63:0] wd [4];
        time t0;
        time t1;
        for (int i = 0; i < 4; i++) wd[i] = {$urandom, $urandom};
        t0 = $time;
        for (int i = 0; i < 4; i++) begin
            xfer(1, 12'(i * 8), 1, wd[i], 8'hFF, 3'b000, rd, se, cyc, pe);
            total++; if (cyc !== 1) begin bad++; $display("[TB] FAIL b2b_wr_latency: word %0d got %0d want 1", i, cyc); end
            total++; if (se !== 1'b0) begin bad++; $display("[TB] FAIL b2b_wr_slverr: word %0d got %b want 0", i, se); end
        end
        for (int i = 0; i < 4; i++) begin
            xfer(1, 12'(i * 8), 0, 64'h0, 8'h0, 3'b000, rd, se, cyc, pe);
            total++; if (rd !== wd[i]) begin bad++; $display("[TB] FAIL b2b_rd_data: word %0d got %h want %h", i, rd, wd[i]); end
            total++; if (cyc !== 1) begin bad++; $display("[TB] FAIL b2b_rd_latency: word %0d got %0d want 1", i, cyc); end
        end
        t1 = $time;
        total++; if ((t1 - t0) !== time'(160)) begin bad++; $display("[TB] FAIL b2b_no_gap: got %0t want 160", t1 - t0); end
        idle(1);
    endtask

`ifdef APB4_SRAM_PARITY_EN
    task automatic test_parity();
        xfer(0, 12'h030, 1, 64'h0000FFFF, 8'hF, 3'b000, rd, se, cyc, pe);
        dut.u_mem.par_q[12][0] = ~dut.u_mem.par_q[12][0];
        xfer(0, 12'h030, 0, 64'h0, 8'h0, 3'b000, rd, se, cyc, pe);
        total++; if (se !== 1'b1) begin bad++; $display("[TB] FAIL parity_slverr: got %b want 1", se); end
        total++; if (pe !== 1'b1) begin bad++; $display("[TB] FAIL parity_err_pulse: got %b want 1", pe); end
        total++; if (rd[31:0] !== 32'h0000FFFF) begin bad++; $display("[TB] FAIL parity_rdata: got %h want 0000ffff", rd[31:0]); end
        @(negedge clk);
        total++; if (parity_err !== 1'b0) begin bad++; $display("[TB] FAIL parity_err_width: got %b want 0", parity_err); end
        @(posedge clk); #1;
        idle(1);
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = '0;
            model_mask[i] = '0;
        end
        test_reset();
        test_basic();
        test_strobes();
        test_errors();
        test_ignore_penable();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef APB4_SRAM_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/apb4_sram.md
APB4_SRAM -- requirements
Module: apb4_sram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 512, number of implemented words; must be at most 2**(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 SHALL have parameter WAIT_STATES, default 1, extra access cycles before pready; range 0..15.
REQ-005 SHALL have parameter PROT_BASE, default DEPTH/2, first word index of the privileged-write region.
REQ-006 SHALL have ports: clk  in  1  clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 paddr  in  ADDR_WIDTH  byte address; psel  in  1; penable  in  1; pwrite  in  1.
REQ-009 pprot  in  3  APB4 protection, bit 0 = privileged; pwdata  in  DATA_WIDTH; pstrb  in  DATA_WIDTH/8.
REQ-010 pready  out  1; prdata  out  DATA_WIDTH; pslverr  out  1.

Function
REQ-011 SHALL use states IDLE, ACCESS; IDLE->ACCESS on psel&!penable (setup); ACCESS->IDLE on completion or abort.
REQ-012 Setup cycle SHALL register paddr, pwrite, pprot, pwdata, pstrb, load wait counter with WAIT_STATES, and compute the error flag.
REQ-013 Error flag SHALL be set when: word index >= DEPTH; paddr low log2(DATA_WIDTH/8) bits nonzero; or write with word index >= PROT_BASE and pprot[0]=0.
REQ-014 In ACCESS the counter SHALL decrement each cycle; pready SHALL be 1 only in the ACCESS cycle where the counter is 0 (WAIT_STATES=0 gives pready in first access cycle).
REQ-015 pslverr SHALL equal the registered error flag while pready=1, else 0.
REQ-016 Write SHALL update only bytes with pstrb[i]=1, at the completing edge, and only when the error flag is 0; pstrb=0 is a legal no-op write.
REQ-017 Read data SHALL be fetched at the setup edge and held stable on prdata throughout ACCESS; prdata SHALL be 0 on error reads.
REQ-018 psel=0 while in ACCESS SHALL abort to IDLE with no write and pready=0.
REQ-019 penable=1 with psel=1 while in IDLE SHALL be ignored (no transfer).
REQ-020 Back-to-back transfers SHALL be supported: a setup in the cycle after completion is accepted with no dead cycle.
REQ-021 prdata SHALL hold its last value when not in ACCESS.

Reset
REQ-022 reset=1 at a clock edge SHALL force IDLE, counter=0, pready=0, pslverr=0, prdata=0.
REQ-023 Reset during ACCESS SHALL abandon the transfer with no memory write; memory contents SHALL NOT be reset.

Configuration
REQ-024 With macro APB4_SRAM_PARITY_EN defined, one even-parity bit per byte SHALL be stored on every byte write, and output port parity_err (1 bit) SHALL be added.
REQ-025 With APB4_SRAM_PARITY_EN, a non-error read whose fetched word has any parity mismatch SHALL set pslverr with pready and pulse parity_err for that cycle; prdata returns the raw data.
REQ-026 Without APB4_SRAM_PARITY_EN, no parity storage or parity_err port SHALL exist and behaviour is REQ-011..021 only.

Structure
REQ-027 Package apb4_sram_pkg SHALL hold the state enum, the maximum wait-state constant (15), and a function mapping byte address to word index.
REQ-028 Storage SHALL be a sub-module apb4_sram_mem: synchronous byte-enable RAM, DEPTH words, registered read, optional parity lanes.

Verification
REQ-029 WAIT_STATES=1: write 0xDEADBEEF to 0x010, pstrb=0xF, pprot=0 -> pready in 2nd access cycle, pslverr=0; read 0x010 -> 0xDEADBEEF.
REQ-030 Byte strobes: write 0x11223344 to 0x020, then 0xAABBCCDD with pstrb=0x5 -> read 0x11BB33DD.
REQ-031 Errors: read word DEPTH (0x800 for defaults), write to 0x802, unprivileged write to word PROT_BASE -> each pslverr=1, target memory unchanged, error reads prdata=0.
REQ-032 WAIT_STATES=0, DATA_WIDTH=64: four back-to-back writes then reads at 0x000..0x018 -> one-cycle access each, data matches, no idle gap.
REQ-033 Abort and reset: drop psel in 1st access cycle of write, and assert reset mid-write -> no pready, memory unchanged, outputs 0 after reset.
REQ-034 APB4_SRAM_PARITY_EN: write 0x0000FFFF, deposit flipped parity bit on byte 0, read -> pslverr=1, parity_err pulses one cycle, prdata=0x0000FFFF.
